// File: rtl/dac_wave_gen.sv
// Phase-accumulator waveform source for the SPI DAC controller.
// Samples are ticked at s_clk/SAMPLE_DIV and issued when the DAC is free.
module dac_wave_gen #(
    parameter int DATA_W     = 10,
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 100
) (
    input  logic               s_clk,
    input  logic               s_rst,
    input  logic               enable,
    input  logic [1:0]         wave_sel,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [1:0]         amp_shift,
    input  logic [DATA_W-1:0]  dc_level,
    input  logic               dac_busy,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    output logic               phase_wrap,
    output logic [7:0]         overrun_cnt
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               pend_q, pend_d;
    logic               wrap_q, wrap_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               pwrap_q, pwrap_d;
    logic [7:0]         ovr_q, ovr_d;

    logic               tick;
    logic               issue;
    logic               carry;
    logic [PHASE_W-1:0] sum;
    logic [DATA_W-1:0]  p;
    logic [DATA_W-1:0]  t;
    logic [DATA_W-1:0]  r;
    logic [DATA_W-1:0]  shaped;

    always_comb begin
        p = acc_q[PHASE_W-1 -: DATA_W];
        t = {p[DATA_W-2:0], 1'b0};
        r = '0;
        unique case (wave_sel)
            2'd0:    r = p;
            2'd1:    r = p[DATA_W-1] ? ~t : t;
            2'd2:    r = p[DATA_W-1] ? '0 : '1;
            default: r = '0;
        endcase
        shaped = (wave_sel == 2'd3) ? dc_level : (r >> amp_shift);
    end

    always_comb begin
        tick         = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));
        issue        = enable && pend_q && !dac_busy;
        {carry, sum} = {1'b0, acc_q} + {1'b0, ftw};

        div_d   = div_q;
        acc_d   = acc_q;
        pend_d  = pend_q;
        wrap_d  = wrap_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        pwrap_d = 1'b0;
        ovr_d   = ovr_q;

        if (!enable) begin
            div_d  = '0;
            acc_d  = '0;
            pend_d = 1'b0;
            wrap_d = 1'b0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (issue) begin
                dout_d  = shaped;
                valid_d = 1'b1;
                pwrap_d = wrap_q;
                wrap_d  = 1'b0;
                pend_d  = 1'b0;
            end
            // A tick on the issue edge re-arms pending with the new phase.
            if (tick) begin
                acc_d  = sum;
                pend_d = 1'b1;
                if (carry)
                    wrap_d = 1'b1;
                if (pend_q && dac_busy && ovr_q != 8'hFF)
                    ovr_d = ovr_q + 8'd1;
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            div_q   <= '0;
            acc_q   <= '0;
            pend_q  <= 1'b0;
            wrap_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            pwrap_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            div_q   <= div_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            wrap_q  <= wrap_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            pwrap_q <= pwrap_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out    = dout_q;
    assign data_valid  = valid_q;
    assign phase_wrap  = pwrap_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Scoreboard bench for dac_wave_gen: main instance at SAMPLE_DIV=100,
// a second at SAMPLE_DIV=4 for tick/issue collisions and saturation.
module tb_dac_wave_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, busy, en4, busy4;
    logic [1:0]  wsel, ash;
    logic [15:0] ftw;
    logic [9:0]  dcl;
    logic [9:0]  dout, dout4;
    logic        dv, pw, dv4, pw4;
    logic [7:0]  ovr, ovr4;

    typedef struct packed {
        logic [9:0] d;
        logic       w;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_wave_gen #(.DATA_W(10), .PHASE_W(16), .SAMPLE_DIV(100)) u_dut (
        .s_clk(clk), .s_rst(rst), .enable(en), .wave_sel(wsel),
        .ftw(ftw), .amp_shift(ash), .dc_level(dcl), .dac_busy(busy),
        .data_out(dout), .data_valid(dv), .phase_wrap(pw),
        .overrun_cnt(ovr)
    );

    dac_wave_gen #(.DATA_W(10), .PHASE_W(16), .SAMPLE_DIV(4)) u_dut4 (
        .s_clk(clk), .s_rst(rst), .enable(en4), .wave_sel(wsel),
        .ftw(ftw), .amp_shift(ash), .dc_level(dcl), .dac_busy(busy4),
        .data_out(dout4), .data_valid(dv4), .phase_wrap(pw4),
        .overrun_cnt(ovr4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, want);
    endtask

    task automatic push(input logic [9:0] d, input logic w);
        exp_t e;
        e.d = d;
        e.w = w;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dv(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dv) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("dv_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (dv) begin
            if (sb.size() == 0) begin
                chk("dv_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("data_out", dout, mon_e.d);
                chk("phase_wrap", pw, mon_e.w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    int tri_tab[8] = '{256, 512, 768, 1023, 767, 511, 255, 0};
    int sq_tab[4]  = '{1023, 0, 0, 1023};

    initial begin
        int t0, t1, t2, tr, nv;
        en = 0; busy = 0; wsel = 0; ash = 0; ftw = 0; dcl = 0;
        en4 = 0; busy4 = 0;
        idle(3);
        chk("rst_dout", dout, 0);
        chk("rst_dv", dv, 0);
        chk("rst_ovr", ovr, 0);
        rst = 0;
        idle(2);

        // sawtooth: 64 samples, wrap on the last
        ftw = 16'h0400;
        for (int k = 1; k <= 64; k++)
            push(10'((k * 16) % 1024), k == 64);
        en = 1;
        t0 = cyc;
        wait_dv(200, t1);
        chk("first_latency", t1 - t0, 101);
        wait_dv(200, t2);
        chk("period", t2 - t1, 100);
        repeat (62) wait_dv(200, t2);
        idle(5);
        en = 0;
        idle(3);
        chk("saw_sb_drained", sb.size(), 0);

        // triangle, then attenuated by 4
        wsel = 1;
        ftw  = 16'h2000;
        for (int i = 0; i < 8; i++)
            push(10'(tri_tab[i]), i == 7);
        en = 1;
        repeat (8) wait_dv(200, t2);
        ash = 2;
        for (int i = 0; i < 8; i++)
            push(10'(tri_tab[i] >> 2), i == 7);
        repeat (8) wait_dv(200, t2);
        en = 0;
        idle(3);

        // square, then DC ignoring attenuation
        wsel = 2;
        ash  = 0;
        ftw  = 16'h4000;
        for (int i = 0; i < 4; i++)
            push(10'(sq_tab[i]), i == 3);
        en = 1;
        repeat (4) wait_dv(200, t2);
        wsel = 3;
        dcl  = 10'd500;
        ash  = 3;
        repeat (3) push(10'd500, 1'b0);
        repeat (3) wait_dv(200, t2);
        en = 0;
        nv = 0;
        repeat (250) begin
            @(negedge clk);
            if (dv) nv++;
        end
        chk("idle_no_dv", nv, 0);
        chk("idle_hold", dout, 500);

        // backpressure across three ticks
        wsel = 0;
        ash  = 0;
        ftw  = 16'h0400;
        busy = 1;
        en   = 1;
        idle(350);
        busy = 0;
        tr   = cyc;
        push(10'd48, 1'b0);
        wait_dv(5, t1);
        chk("bp_latency", t1 - tr, 1);
        chk("bp_overrun", ovr, 2);
        idle(3);
        en = 0;
        idle(3);

        // SAMPLE_DIV=4: release busy in the tick cycle while pending
        busy4 = 1;
        en4   = 1;
        idle(7);
        busy4 = 0;
        @(negedge clk);
        chk("sim_dv1", dv4, 1);
        chk("sim_d1", dout4, 16);
        @(negedge clk);
        chk("sim_dv2", dv4, 1);
        chk("sim_d2", dout4, 32);
        chk("sim_ovr", ovr4, 0);

        // busy held: overrun saturates, nothing issued
        busy4 = 1;
        nv = 0;
        repeat (1200) begin
            @(negedge clk);
            if (dv4) nv++;
        end
        chk("sat_no_dv", nv, 0);
        chk("sat_ovr", ovr4, 255);
        busy4 = 0;
        @(negedge clk);
        chk("sat_release_dv", dv4, 1);
        en4 = 0;
        idle(2);

        // asynchronous reset mid-run
        push(10'd16, 1'b0);
        push(10'd32, 1'b0);
        en = 1;
        repeat (2) wait_dv(200, t2);
        idle(50);
        chk("pre_rst_ovr", ovr, 2);
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_ovr", ovr, 0);
        chk("arst_dv", dv, 0);
        chk("arst_ovr4", ovr4, 0);
        @(negedge clk);
        en  = 0;
        rst = 0;
        idle(2);
        push(10'd16, 1'b0);
        en = 1;
        t0 = cyc;
        wait_dv(200, t1);
        chk("arst_latency", t1 - t0, 101);
        idle(3);
        en = 0;
        idle(2);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
